// File: rtl/rle_vga_pkg.sv
// Shared constants and token-layout helpers for the RLE span decode path
// between the flash token reader and the VGA pixel output.
package rle_vga_pkg;

  localparam int unsigned DefColourBits = 6;
  localparam int unsigned DefRunBits    = 10;
  localparam int unsigned DefFifoDepth  = 4;

  // Colour driven during blanking, underrun and after a frame flush.
  localparam int unsigned BlankColour = 0;

  // Token layout: {run, colour}, colour in the low bits.
  function automatic int unsigned tok_colour_lsb();
    return 0;
  endfunction

  function automatic int unsigned tok_run_lsb(input int unsigned colour_bits);
    return colour_bits;
  endfunction

  function automatic int unsigned tok_width(input int unsigned run_bits,
                                            input int unsigned colour_bits);
    return run_bits + colour_bits;
  endfunction

endpackage

// File: rtl/rle_token_fifo.sv
// Small synchronous token FIFO with count-based full/empty and a
// combinational head; flush empties it in one cycle.
module rle_token_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when a pop frees a slot this cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only visible once counted in.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rle_span_decoder.sv
// Expands buffered {run, colour} tokens into one registered colour per
// active pixel, with sticky underrun and frame-start resynchronisation.
module rle_span_decoder
  import rle_vga_pkg::*;
#(
  parameter int unsigned COLOUR_BITS = DefColourBits,
  parameter int unsigned RUN_BITS    = DefRunBits,
  parameter int unsigned FIFO_DEPTH  = DefFifoDepth
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [RUN_BITS+COLOUR_BITS-1:0] tok_data,
  input  logic                            tok_valid,
  output logic                            tok_ready,
  input  logic                            frame_start,
  input  logic                            pix_en,
  output logic [COLOUR_BITS-1:0]          colour,
  output logic                            underrun
);

  localparam int unsigned TokW      = tok_width(RUN_BITS, COLOUR_BITS);
  localparam int unsigned RunLsb    = tok_run_lsb(COLOUR_BITS);
  localparam int unsigned ColourLsb = tok_colour_lsb();

  logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [TokW-1:0]        fifo_head;
  logic [RUN_BITS-1:0]    head_run;
  logic [COLOUR_BITS-1:0] head_colour;

  logic [RUN_BITS-1:0]    remaining_q, remaining_d;
  logic [COLOUR_BITS-1:0] cur_colour_q, cur_colour_d;
  logic [COLOUR_BITS-1:0] colour_q, colour_d;
  logic                   underrun_q, underrun_d;

  assign tok_ready   = ~fifo_full & ~frame_start;
  assign fifo_push   = tok_valid & tok_ready;
  assign head_run    = fifo_head[RunLsb +: RUN_BITS];
  assign head_colour = fifo_head[ColourLsb +: COLOUR_BITS];

  rle_token_fifo #(
    .WIDTH (TokW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (fifo_push),
    .din   (tok_data),
    .pop   (fifo_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    remaining_d  = remaining_q;
    cur_colour_d = cur_colour_q;
    colour_d     = colour_q;
    underrun_d   = underrun_q;
    fifo_pop     = 1'b0;
    if (frame_start) begin
      remaining_d  = '0;
      cur_colour_d = COLOUR_BITS'(BlankColour);
      colour_d     = COLOUR_BITS'(BlankColour);
      underrun_d   = 1'b0;
    end else if (!pix_en) begin
      colour_d = COLOUR_BITS'(BlankColour);
    end else if (remaining_q != '0) begin
      colour_d    = cur_colour_q;
      remaining_d = remaining_q - RUN_BITS'(1);
    end else if (!fifo_empty) begin
      // Run field N means N+1 pixels: this cycle is the first of them.
      fifo_pop     = 1'b1;
      colour_d     = head_colour;
      cur_colour_d = head_colour;
      remaining_d  = head_run;
    end else begin
      colour_d   = COLOUR_BITS'(BlankColour);
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      remaining_q  <= '0;
      cur_colour_q <= '0;
      colour_q     <= '0;
      underrun_q   <= 1'b0;
    end else begin
      remaining_q  <= remaining_d;
      cur_colour_q <= cur_colour_d;
      colour_q     <= colour_d;
      underrun_q   <= underrun_d;
    end
  end

  assign colour   = colour_q;
  assign underrun = underrun_q;

endmodule
